// File: rtl/gate_stream_unit.sv
// Streaming two-operand gate with valid/ready handshake and optional frame reduction.
// One registered result per accepted beat (per-beat mode) or per closed frame (accumulate mode).
module gate_stream_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op,
   input  logic             acc_en,
   input  logic             in_last,
   output logic [WIDTH-1:0] Q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [CNT_W-1:0] beat_count
);

   typedef enum logic {IDLE, ACCUM} state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [2:0]       frame_op_q, frame_op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [CNT_W-1:0] beat_count_q, beat_count_d;

   logic             accept;
   logic [2:0]       eff_op;
   logic [WIDTH-1:0] beat_v;
   logic [WIDTH-1:0] fold_v;
   logic [CNT_W-1:0] cnt_inc;

   function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] sel,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (sel)
         3'b000:  gate_f = a & b;
         3'b001:  gate_f = a | b;
         3'b010:  gate_f = a ^ b;
         3'b011:  gate_f = ~(a & b);
         3'b100:  gate_f = ~(a | b);
         3'b101:  gate_f = ~(a ^ b);
         3'b110:  gate_f = ~a;
         default: gate_f = a;
      endcase
   endfunction

   // Reduction pairs each gate with its underlying associative operator.
   function automatic logic [WIDTH-1:0] reduce_f(input logic [2:0] sel,
                                                 input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] v);
      case (sel)
         3'b000, 3'b011: reduce_f = acc & v;
         3'b001, 3'b100: reduce_f = acc | v;
         3'b010, 3'b101: reduce_f = acc ^ v;
         default:        reduce_f = v;
      endcase
   endfunction

   assign in_ready = !(out_valid_q && !out_ready);
   assign accept   = in_valid && in_ready;
   assign eff_op   = (state_q == ACCUM) ? frame_op_q : op;
   assign beat_v   = gate_f(eff_op, A, B);
   assign fold_v   = reduce_f(eff_op, acc_q, beat_v);
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         frame_op_q   <= 3'b000;
         acc_q        <= '0;
         cnt_q        <= '0;
         q_q          <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         beat_count_q <= '0;
      end else begin
         state_q      <= state_d;
         frame_op_q   <= frame_op_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         q_q          <= q_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         beat_count_q <= beat_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      frame_op_d   = frame_op_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      q_d          = q_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_last_d   = out_last_q;
      beat_count_d = beat_count_q;

      if (accept) begin
         case (state_q)
            IDLE: begin
               if (acc_en) begin
                  frame_op_d = op;
               end
               if (!acc_en || in_last) begin
                  q_d          = beat_v;
                  out_last_d   = in_last;
                  beat_count_d = CNT_ONE;
                  out_valid_d  = 1'b1;
               end else begin
                  acc_d   = beat_v;
                  cnt_d   = CNT_ONE;
                  state_d = ACCUM;
               end
            end
            default: begin
               if (!in_last) begin
                  acc_d = fold_v;
                  cnt_d = cnt_inc;
               end else begin
                  q_d          = fold_v;
                  beat_count_d = cnt_inc;
                  out_last_d   = 1'b1;
                  out_valid_d  = 1'b1;
                  state_d      = IDLE;
               end
            end
         endcase
      end
   end

   assign Q          = q_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign beat_count = beat_count_q;

endmodule
